// File: rtl/hamming32t26d_scrubber.sv
// hamming32t26d_scrubber
//   Background scrubber for SRAM protected by the hamming32t26d SEC-DED code.
//   It walks word addresses 0..DEPTH-1, reads each codeword, decodes it,
//   writes back single-bit-corrected words re-encoded, and logs uncorrectable
//   (double) errors. It acts as a low-priority requester behind the arbiter.
//
//   Codeword layout (extended Hamming, 26 data + 5 check + 1 overall parity):
//     bit 0               overall even parity over bits 31..1
//     bits 1,2,4,8,16     check bits; bit 2**k covers positions with index bit k set
//     remaining bits      data bits 0..25 in ascending position order
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   scrub_en_i, interval_i     enable, idle cycles between word scrubs
//   clr_cnt_i                  clear sec/ded counters and ded_valid_o
//   mem_req_o/we_o/lock_o      memory request, write flag, arbiter lock
//   mem_addr_o, mem_wdata_o    word address, re-encoded write data
//   mem_gnt_i, mem_rvalid_i    request accepted, read data valid
//   mem_rdata_i                read codeword
//   sec_cnt_o, ded_cnt_o       saturating corrected / uncorrectable counts
//   ded_addr_o, ded_valid_o    address of the latest DED and its valid flag
//   ded_irq_o, pass_done_o     one-cycle event pulses
//   busy_o                     FSM not idle
module hamming32t26d_scrubber #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                scrub_en_i,
  input  logic [PERIOD_W-1:0] interval_i,
  input  logic                clr_cnt_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                mem_lock_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [CNT_W-1:0]    sec_cnt_o,
  output logic [CNT_W-1:0]    ded_cnt_o,
  output logic [ADDR_W-1:0]   ded_addr_o,
  output logic                ded_valid_o,
  output logic                ded_irq_o,
  output logic                pass_done_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_RD_WAIT,
    S_CHECK,
    S_WR,
    S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PERIOD_W-1:0] wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    sec_q, sec_d;
  logic [CNT_W-1:0]    ded_q, ded_d;
  logic [ADDR_W-1:0]   ded_addr_q, ded_addr_d;
  logic                ded_valid_q, ded_valid_d;
  logic                ded_irq_q, ded_irq_d;
  logic                pass_done_q, pass_done_d;

  // Positions 1,2,4,8,16 carry check bits.
  function automatic logic is_chk(input logic [4:0] p);
    return (p & (p - 5'd1)) == 5'd0;
  endfunction

  function automatic logic [31:0] enc(input logic [25:0] d);
    logic [31:0] c;
    logic [4:0]  j;
    logic        par;
    c = '0;
    j = '0;
    for (int unsigned p = 1; p < 32; p++) begin
      if (!is_chk(p[4:0])) begin
        c[p[4:0]] = d[j];
        j = j + 5'd1;
      end
    end
    for (int unsigned k = 0; k < 5; k++) begin
      par = 1'b0;
      for (int unsigned p = 1; p < 32; p++) begin
        if (!is_chk(p[4:0]) && p[k[4:0]]) par = par ^ c[p[4:0]];
      end
      c[5'd1 << k[2:0]] = par;
    end
    c[0] = ^c[31:1];
    return c;
  endfunction

  function automatic logic [25:0] extract(input logic [31:0] c);
    logic [25:0] d;
    logic [4:0]  j;
    d = '0;
    j = '0;
    for (int unsigned p = 1; p < 32; p++) begin
      if (!is_chk(p[4:0])) begin
        d[j] = c[p[4:0]];
        j = j + 5'd1;
      end
    end
    return d;
  endfunction

  // Decode of the captured word. A single error always flips overall parity;
  // syndrome 0 with bad parity means the parity bit itself was hit.
  logic [4:0]  syn;
  logic        par_err;
  logic        ded;
  logic [31:0] corrected;
  logic [31:0] reenc;

  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p < 32; p++) begin
      if (rdata_q[p[4:0]]) syn = syn ^ p[4:0];
    end
    par_err   = ^rdata_q;
    corrected = rdata_q;
    if (par_err) corrected[syn] = ~corrected[syn];
    ded   = !par_err && (syn != 5'd0);
    reenc = enc(extract(corrected));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    wdata_d     = wdata_q;
    sec_d       = sec_q;
    ded_d       = ded_q;
    ded_addr_d  = ded_addr_q;
    ded_valid_d = ded_valid_q;
    ded_irq_d   = 1'b0;
    pass_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scrub_en_i) begin
          wait_d  = interval_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_RD;
        else              wait_d  = wait_q - PERIOD_W'(1);
      end
      S_RD: begin
        if (mem_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ded) begin
          if (ded_q != '1) ded_d = ded_q + CNT_W'(1);
          ded_addr_d  = addr_q;
          ded_valid_d = 1'b1;
          ded_irq_d   = 1'b1;
          state_d     = S_NEXT;
        end else if (reenc != rdata_q) begin
          if (sec_q != '1) sec_d = sec_q + CNT_W'(1);
          wdata_d = reenc;
          state_d = S_WR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR: begin
        if (mem_gnt_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          addr_d      = '0;
          pass_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (scrub_en_i) begin
          wait_d  = interval_i;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear is applied last so it overrides an increment in the same cycle.
    if (clr_cnt_i) begin
      sec_d       = '0;
      ded_d       = '0;
      ded_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      sec_q       <= '0;
      ded_q       <= '0;
      ded_addr_q  <= '0;
      ded_valid_q <= 1'b0;
      ded_irq_q   <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      wdata_q     <= wdata_d;
      sec_q       <= sec_d;
      ded_q       <= ded_d;
      ded_addr_q  <= ded_addr_d;
      ded_valid_q <= ded_valid_d;
      ded_irq_q   <= ded_irq_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign mem_req_o   = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we_o    = (state_q == S_WR);
  assign mem_lock_o  = (state_q == S_RD) || (state_q == S_RD_WAIT) ||
                       (state_q == S_CHECK) || (state_q == S_WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign sec_cnt_o   = sec_q;
  assign ded_cnt_o   = ded_q;
  assign ded_addr_o  = ded_addr_q;
  assign ded_valid_o = ded_valid_q;
  assign ded_irq_o   = ded_irq_q;
  assign pass_done_o = pass_done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hamming32t26d_scrubber.sv
// Testbench for hamming32t26d_scrubber: a memory responder with a golden
// codeword image drives the DUT; expected scrub results come from counting
// the bits the bench itself flipped in each stored word.
module tb_hamming32t26d_scrubber;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 8;
  localparam int PERIOD_W = 4;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic                clr = 1'b0;
  logic [PERIOD_W-1:0] interval = '0;
  logic                mem_req_o, mem_we_o, mem_lock_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [31:0]         mem_wdata_o;
  logic                mem_gnt_i = 1'b0;
  logic                mem_rvalid_i = 1'b0;
  logic [31:0]         mem_rdata_i = '0;
  logic [CNT_W-1:0]    sec_cnt_o, ded_cnt_o;
  logic [ADDR_W-1:0]   ded_addr_o;
  logic                ded_valid_o, ded_irq_o, pass_done_o, busy_o;

  hamming32t26d_scrubber #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .scrub_en_i(en), .interval_i(interval),
    .clr_cnt_i(clr), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_lock_o(mem_lock_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o), .ded_addr_o(ded_addr_o),
    .ded_valid_o(ded_valid_o), .ded_irq_o(ded_irq_o), .pass_done_o(pass_done_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] golden[DEPTH];
  logic [31:0] mem[DEPTH];

  // responder configuration
  int rd_stall = 0, wr_stall = 0, rv_dly = 0, clr_addr = -1;
  bit rand_mode = 1'b0;

  // logs filled by the responder
  int          rd_log[$];
  int          rd_cyc[$];
  int          wr_a_log[$];
  logic [31:0] wr_d_log[$];
  int irq_hi = 0, pd_hi = 0, pd_cyc = 0, stall_seen = 0, cyc = 0;

  // responder internal state
  bit acc_v = 0, acc_we = 0, pend = 0, in_req = 0, clr_pending = 0;
  int acc_addr = 0, pend_addr = 0, pend_dly = 0, stall = 0;
  logic [31:0] acc_wd = '0, h_wd = '0;
  logic [ADDR_W-1:0] h_addr = '0;
  logic h_we = 1'b0;

  // expected architectural state
  int ptr = 0, e_sec = 0, e_ded = 0, e_dad = 0, e_dv = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Codeword from the code's definition: data fills non-power-of-two
  // positions, check bits make the position-XOR of all set bits zero,
  // bit 0 makes total parity even.
  function automatic logic [31:0] model_enc(input logic [25:0] d);
    logic [31:0] w;
    int j, syn;
    logic [4:0] pos;
    w = '0; j = 0; syn = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p[4:0]] = d[j[4:0]];
        if (d[j[4:0]]) syn = syn ^ p;
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      pos = 5'(1 << k);
      w[pos] = syn[k[4:0]];
    end
    w[0] = ^w;
    return w;
  endfunction

  always @(negedge clk) begin
    cyc++;
    mem_rvalid_i = 1'b0;
    clr = 1'b0;
    if (clr_pending) begin
      clr = 1'b1;
      clr_pending = 0;
    end
    if (rst) begin
      acc_v = 0; pend = 0; in_req = 0; clr_pending = 0; mem_gnt_i = 1'b0;
    end else begin
      if (acc_v) begin
        if (acc_we) begin
          if (acc_addr < DEPTH) mem[acc_addr] = acc_wd;
          wr_a_log.push_back(acc_addr);
          wr_d_log.push_back(acc_wd);
        end else begin
          rd_log.push_back(acc_addr);
          rd_cyc.push_back(cyc);
          pend = 1;
          pend_addr = acc_addr;
          pend_dly = rand_mode ? $urandom_range(0, 3) : rv_dly;
        end
        acc_v = 0;
      end
      if (pend) begin
        if (pend_dly == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = (pend_addr < DEPTH) ? mem[pend_addr] : 32'h0;
          pend = 0;
          if (pend_addr == clr_addr) clr_pending = 1;
        end else begin
          pend_dly--;
          mem_rdata_i = $urandom;
        end
      end else if (rand_mode && $urandom_range(0, 3) == 0) begin
        mem_rvalid_i = 1'b1;  // stray rvalid the scrubber must ignore
        mem_rdata_i = $urandom;
      end
      if (ded_irq_o) irq_hi++;
      if (pass_done_o) begin
        pd_hi++;
        pd_cyc = cyc;
      end
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
        chk("lock_with_req", mem_lock_o, 1);
        if (!in_req) begin
          in_req = 1;
          h_addr = mem_addr_o; h_we = mem_we_o; h_wd = mem_wdata_o;
          stall = mem_we_o ? wr_stall : rd_stall;
          if (rand_mode) stall = $urandom_range(0, 3);
        end else begin
          chk("stall_addr", mem_addr_o, h_addr);
          chk("stall_we", mem_we_o, h_we);
          if (h_we) chk("stall_wdata", mem_wdata_o, h_wd);
        end
        if (stall > 0) begin
          stall--;
          stall_seen++;
        end else begin
          mem_gnt_i = 1'b1;
          acc_v = 1; acc_we = mem_we_o; acc_addr = mem_addr_o; acc_wd = mem_wdata_o;
          in_req = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_words(input int n);
    logic [31:0] m[DEPTH];
    int          e_wa[$];
    logic [31:0] e_wd[$];
    int e_irq, e_pd, a, f;
    e_irq = 0; e_pd = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = mem[i];
    for (int i = 0; i < n; i++) begin
      a = (ptr + i) % DEPTH;
      f = $countones(m[a] ^ golden[a]);
      if (f == 1) begin
        e_wa.push_back(a);
        e_wd.push_back(golden[a]);
        m[a] = golden[a];
        if (e_sec < CNT_MAX) e_sec++;
      end else if (f == 2) begin
        if (e_ded < CNT_MAX) e_ded++;
        e_dad = a; e_dv = 1; e_irq++;
      end
      if (a == DEPTH - 1) e_pd++;
      if (a == clr_addr) begin
        e_sec = 0; e_ded = 0; e_dv = 0;
      end
    end
    rd_log.delete(); rd_cyc.delete(); wr_a_log.delete(); wr_d_log.delete();
    irq_hi = 0; pd_hi = 0; stall_seen = 0;
    en = 1'b1;
    for (int k = 0; k < 3000 && rd_log.size() < n; k++) tick();
    chk("read_timeout", rd_log.size() >= n, 1);
    en = 1'b0;
    for (int k = 0; k < 300 && busy_o; k++) tick();
    chk("idle_timeout", busy_o, 0);
    repeat (3) tick();
    chk("read_count", rd_log.size(), n);
    for (int i = 0; i < n; i++) chk("read_addr", rd_log[i], (ptr + i) % DEPTH);
    chk("write_count", wr_a_log.size(), e_wa.size());
    for (int i = 0; i < e_wa.size(); i++) begin
      chk("write_addr", wr_a_log[i], e_wa[i]);
      chk("write_data", wr_d_log[i], e_wd[i]);
    end
    chk("sec_cnt", sec_cnt_o, e_sec);
    chk("ded_cnt", ded_cnt_o, e_ded);
    chk("ded_valid", ded_valid_o, e_dv);
    chk("ded_addr", ded_addr_o, e_dad);
    chk("ded_irq_cycles", irq_hi, e_irq);
    chk("pass_done_cycles", pd_hi, e_pd);
    ptr = (ptr + n) % DEPTH;
  endtask

  initial begin
    int b0, b1;
    for (int i = 0; i < DEPTH; i++) begin
      golden[i] = model_enc(26'($urandom));
      mem[i] = golden[i];
    end
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_lock", mem_lock_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_sec", sec_cnt_o, 0);
    chk("rst_ded", ded_cnt_o, 0);
    chk("rst_ded_addr", ded_addr_o, 0);
    chk("rst_ded_valid", ded_valid_o, 0);
    chk("rst_irq", ded_irq_o, 0);
    chk("rst_pass_done", pass_done_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    tick();

    // clean pass
    run_words(8);
    chk("clean_word_time", rd_cyc[1] - rd_cyc[0], 5);
    chk("pass_done_after_last", pd_cyc > rd_cyc[7], 1);

    // single-bit error in word 3
    mem[3] = mem[3] ^ (32'd1 << 9);
    run_words(8);
    chk("sec_word_time", rd_cyc[4] - rd_cyc[3], 6);

    // double error in word 6
    mem[6] = mem[6] ^ (32'd1 << 5) ^ (32'd1 << 12);
    run_words(8);
    mem[6] = golden[6];

    // long write stall
    mem[2] = mem[2] ^ (32'd1 << $urandom_range(0, 31));
    wr_stall = 10;
    run_words(8);
    chk("wr_stall_cycles", stall_seen, 10);
    wr_stall = 0;

    // disable during RD_WAIT of word 4, then resume
    rv_dly = 2;
    run_words(5);
    rv_dly = 0;
    run_words(3);
    chk("resume_addr", rd_log[0], 5);

    // clear coinciding with a SEC increment
    mem[1] = mem[1] ^ (32'd1 << $urandom_range(0, 31));
    clr_addr = 1;
    run_words(8);
    clr_addr = -1;
    chk("clr_wins_sec", sec_cnt_o, 0);

    // 2**CNT_W + 1 corrections saturate
    for (int i = 0; i < DEPTH; i++) mem[i] = golden[i] ^ (32'd1 << $urandom_range(0, 31));
    run_words(8);
    mem[0] = golden[0] ^ (32'd1 << $urandom_range(0, 31));
    run_words(8);
    chk("sec_saturated", sec_cnt_o, CNT_MAX);

    // nonzero idle interval
    interval = 4'd3;
    run_words(2);
    chk("interval_word_time", rd_cyc[1] - rd_cyc[0], 8);
    interval = '0;

    // randomized errors, stalls, read latency, stray rvalid
    rand_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = golden[i];
        case ($urandom_range(0, 3))
          2: mem[i] = mem[i] ^ (32'd1 << $urandom_range(0, 31));
          3: begin
            b0 = $urandom_range(0, 31);
            b1 = (b0 + $urandom_range(1, 31)) % 32;
            mem[i] = mem[i] ^ (32'd1 << b0) ^ (32'd1 << b1);
          end
          default: ;
        endcase
      end
      run_words(12);
    end
    rand_mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = golden[i];

    // reset in the middle of a word
    en = 1'b1;
    for (int k = 0; k < 100 && !mem_req_o; k++) tick();
    chk("req_before_reset", mem_req_o, 1);
    rst = 1'b1;
    tick();
    chk("midrst_req", mem_req_o, 0);
    chk("midrst_lock", mem_lock_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_sec", sec_cnt_o, 0);
    chk("midrst_ded_valid", ded_valid_o, 0);
    en = 1'b0;
    rst = 1'b0;
    tick();
    ptr = 0; e_sec = 0; e_ded = 0; e_dad = 0; e_dv = 0;
    run_words(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
